// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM states, default frame width and the
// chip-select encodings also used by the master-side decoder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_slave_state_t;

  localparam int SPI_DATA_WIDTH = 8;

  // Active-low chip selects, one bit per slave
  localparam logic [2:0] SPI_CS_NONE   = 3'b111;
  localparam logic [2:0] SPI_CS_SLAVE0 = 3'b110;
  localparam logic [2:0] SPI_CS_SLAVE1 = 3'b101;
  localparam logic [2:0] SPI_CS_SLAVE2 = 3'b011;

endpackage

// File: rtl/spi_slave_port_if.sv
// Bundle of the serial pins plus the local-side tx/rx handshake of the SPI slave.
interface spi_slave_port_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
) ();
  logic                  SCLK;
  logic                  CS;
  logic                  MOSI;
  logic                  MISO;
  logic [DATA_WIDTH-1:0] slaveDataToSend;
  logic                  txLoad;
  logic                  txReady;
  logic [DATA_WIDTH-1:0] slaveDataReceived;
  logic                  rxValid;
  logic                  busy;
  logic                  rxOverrun;
  logic                  rxAck;

  modport slave (
    input  SCLK, CS, MOSI, slaveDataToSend, txLoad, rxAck,
    output MISO, txReady, slaveDataReceived, rxValid, busy, rxOverrun
  );

  modport master (
    output SCLK, CS, MOSI, slaveDataToSend, txLoad, rxAck,
    input  MISO, txReady, slaveDataReceived, rxValid, busy, rxOverrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with one history flop; rise/fall are single-cycle
// pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= {STAGES{RESET_VAL}};
      hist <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;
endmodule

// File: rtl/spi_slave_port.sv
// Oversampled SPI slave: one byte in on MOSI and one reply byte out on MISO per
// frame, both LSB first, with back-to-back frames allowed while CS stays low.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  spi_slave_port_if.slave bus
);
  localparam int              CW       = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [1:0]      S_IDLE   = IDLE;
  localparam logic [1:0]      S_SHIFT  = SHIFT;
  localparam logic [1:0]      S_DONE   = DONE;

  logic                  sclk_rise, sclk_fall, sclk_unused;
  logic                  cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                  mosi_q;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rx_sr, tx_sr, tx_buf, rx_data, tx_next;
  logic                  miso, rx_valid, pending, overrun;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d(bus.SCLK),
    .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(bus.CS),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as the edge detectors so MOSI lines up with its SCLK rise
  always_ff @(posedge clk) begin
    if (!reset) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  // A load coinciding with the CS fall goes straight into the frame
  assign tx_next = bus.txLoad ? bus.slaveDataToSend : tx_buf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      tx_buf   <= '0;
      rx_data  <= '0;
      miso     <= 1'b0;
      rx_valid <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (bus.rxAck) pending <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.txLoad) tx_buf <= bus.slaveDataToSend;
          if (cs_fall) begin
            state <= S_SHIFT;
            tx_sr <= tx_next;
            miso  <= tx_next[0];
            rx_sr <= '0;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          if (cnt == CNT_FULL) begin
            state    <= S_DONE;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            cnt      <= '0;
            tx_sr    <= tx_buf;
            pending  <= 1'b1;
            if (pending && !bus.rxAck) overrun <= 1'b1;
          end else if (cs_rise) begin
            state <= S_IDLE;
            miso  <= 1'b0;
            cnt   <= '0;
          end else begin
            if (sclk_rise) begin
              rx_sr <= {mosi_q, rx_sr[DATA_WIDTH-1:1]};
              cnt   <= cnt + CW'(1);
            end
            // A fall before any rise of this frame is the trailing edge of the
            // previous byte: present bit 0 of the reloaded reply instead of shifting
            if (sclk_fall) begin
              if (cnt == '0) begin
                miso <= tx_sr[0];
              end else begin
                miso  <= tx_sr[1];
                tx_sr <= {1'b0, tx_sr[DATA_WIDTH-1:1]};
              end
            end
          end
        end
        S_DONE: begin
          if (cs_q) begin
            state <= S_IDLE;
            miso  <= 1'b0;
          end else begin
            state <= S_SHIFT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.MISO              = miso;
  assign bus.txReady           = (state == S_IDLE);
  assign bus.busy              = (state != S_IDLE);
  assign bus.slaveDataReceived = rx_data;
  assign bus.rxValid           = rx_valid;
  assign bus.rxOverrun         = overrun;
endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: bit-banged master at clk/8, scoreboard of expected
// received bytes consumed on every rxValid pulse.
module tb_spi_slave_port;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;
  logic [7:0] exp_q[$];

  spi_slave_port_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.rxValid === 1'b1) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %h, no byte expected", bus.slaveDataReceived);
        end else begin
          e = exp_q.pop_front();
          if (bus.slaveDataReceived !== e) begin
            errors++;
            $display("FAIL rx_data: got %h, expected %h", bus.slaveDataReceived, e);
          end
        end
      end
    end
  endtask

  task automatic load(input logic [7:0] b);
    bus.slaveDataToSend = b;
    bus.txLoad = 1'b1;
    clks(1);
    bus.txLoad = 1'b0;
  endtask

  task automatic ack();
    bus.rxAck = 1'b1;
    clks(1);
    bus.rxAck = 1'b0;
  endtask

  task automatic cs_low();
    bus.CS = 1'b0;
    clks(6);
  endtask

  task automatic cs_high();
    bus.CS = 1'b1;
    clks(8);
  endtask

  // LSB first; MISO sampled just before each rising SCLK
  task automatic send_byte(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
    miso_b = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = mosi_b[i];
      clks(4);
      miso_b[i] = bus.MISO;
      bus.SCLK = 1'b1;
      clks(4);
      bus.SCLK = 1'b0;
    end
    clks(4);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.SCLK = ~bus.SCLK;
      @(posedge clk);
      #1;
    end
    bus.SCLK = 1'b0;
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b, expected 0", bus.MISO); end
    checks++; if (bus.txReady !== 1'b1) begin errors++; $display("FAIL reset_txready: got %b, expected 1", bus.txReady); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    checks++; if (bus.rxOverrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, expected 0", bus.rxOverrun); end
    checks++; if (bus.slaveDataReceived !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", bus.slaveDataReceived); end
    reset = 1'b1;
    clks(4);
    checks++; if (pulses != 0) begin errors++; $display("FAIL reset_rxvalid: got %0d pulses, expected 0", pulses); end
  endtask

  task automatic test_basic();
    logic [7:0] m;
    int p0;
    p0 = pulses;
    load(8'hA5);
    exp_q.push_back(8'h3C);
    cs_low();
    send_byte(8'h3C, 8, m);
    checks++; if (m !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h, expected a5", m); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hi: got %b, expected 1", bus.busy); end
    cs_high();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_lo: got %b, expected 0", bus.busy); end
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL basic_miso_idle: got %b, expected 0", bus.MISO); end
    checks++; if (bus.slaveDataReceived !== 8'h3C) begin errors++; $display("FAIL basic_data: got %h, expected 3c", bus.slaveDataReceived); end
    checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL basic_pulses: got %0d, expected 1", pulses - p0); end
    ack();
    checks++; if (bus.rxOverrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b, expected 0", bus.rxOverrun); end
  endtask

  task automatic test_abort();
    logic [7:0] m;
    int p0;
    p0 = pulses;
    cs_low();
    send_byte(8'h77, 5, m);
    cs_high();
    checks++; if (pulses != p0) begin errors++; $display("FAIL abort_pulses: got %0d, expected 0", pulses - p0); end
    checks++; if (bus.slaveDataReceived !== 8'h3C) begin errors++; $display("FAIL abort_data: got %h, expected 3c", bus.slaveDataReceived); end
    checks++; if (bus.txReady !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got txReady=%b busy=%b, expected 1/0", bus.txReady, bus.busy); end
  endtask

  task automatic test_txload_ignored();
    logic [7:0] m;
    load(8'h5A);
    exp_q.push_back(8'h11);
    cs_low();
    checks++; if (bus.txReady !== 1'b0) begin errors++; $display("FAIL ign_txready: got %b, expected 0", bus.txReady); end
    load(8'h55);
    send_byte(8'h11, 8, m);
    checks++; if (m !== 8'h5A) begin errors++; $display("FAIL ign_miso1: got %h, expected 5a", m); end
    cs_high();
    ack();
    exp_q.push_back(8'h22);
    cs_low();
    send_byte(8'h22, 8, m);
    checks++; if (m !== 8'h5A) begin errors++; $display("FAIL ign_miso2: got %h, expected 5a", m); end
    cs_high();
    ack();
    checks++; if (bus.slaveDataReceived !== 8'h22) begin errors++; $display("FAIL ign_data: got %h, expected 22", bus.slaveDataReceived); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    int p0;
    p0 = pulses;
    checks++; if (bus.rxOverrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_pre: got %b, expected 0", bus.rxOverrun); end
    load(8'h96);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    cs_low();
    send_byte(8'h01, 8, m1);
    send_byte(8'hFF, 8, m2);
    cs_high();
    checks++; if (m1 !== 8'h96) begin errors++; $display("FAIL b2b_miso1: got %h, expected 96", m1); end
    checks++; if (m2 !== 8'h96) begin errors++; $display("FAIL b2b_miso2: got %h, expected 96", m2); end
    checks++; if (pulses - p0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d, expected 2", pulses - p0); end
    checks++; if (bus.slaveDataReceived !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h, expected ff", bus.slaveDataReceived); end
    checks++; if (bus.rxOverrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b, expected 1", bus.rxOverrun); end
    ack();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] m;
    int p0;
    load(8'hC3);
    cs_low();
    send_byte(8'hF0, 4, m);
    reset = 1'b0;
    clks(1);
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b, expected 0", bus.MISO); end
    checks++; if (bus.txReady !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got txReady=%b busy=%b, expected 1/0", bus.txReady, bus.busy); end
    checks++; if (bus.rxValid !== 1'b0 || bus.rxOverrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got rxValid=%b rxOverrun=%b, expected 0/0", bus.rxValid, bus.rxOverrun); end
    checks++; if (bus.slaveDataReceived !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h, expected 00", bus.slaveDataReceived); end
    reset = 1'b1;
    clks(6);
    cs_high();
    p0 = pulses;
    exp_q.push_back(8'h81);
    // txLoad lands in the same cycle the synchronized CS fall is acted on
    bus.CS = 1'b0;
    clks(2);
    bus.slaveDataToSend = 8'hE7;
    bus.txLoad = 1'b1;
    clks(1);
    bus.txLoad = 1'b0;
    clks(4);
    send_byte(8'h81, 8, m);
    checks++; if (m !== 8'hE7) begin errors++; $display("FAIL simul_load_miso: got %h, expected e7", m); end
    cs_high();
    checks++; if (bus.slaveDataReceived !== 8'h81) begin errors++; $display("FAIL rstmid_frame_data: got %h, expected 81", bus.slaveDataReceived); end
    checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL rstmid_pulses: got %0d, expected 1", pulses - p0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    reset = 1'b0;
    bus.SCLK = 1'b0;
    bus.CS = 1'b1;
    bus.MOSI = 1'b0;
    bus.slaveDataToSend = 8'h00;
    bus.txLoad = 1'b0;
    bus.rxAck = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_abort();
    test_txload_ignored();
    test_back_to_back();
    test_reset_midframe();
    clks(4);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d bytes left, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
